// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//
// Contents:
//   tx_state_t          one-hot FSM encoding (IDLE/START/DATA/PARITY/STOP)
//   TICKS_OVERSAMPLING  baud ticks per bit period (16x oversampling)
//   DEFAULT_MAXTAM      default number of data bits per frame
//   TICK_W              width of the oversampling tick counter (covers up to 32)
package uart_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } tx_state_t;

    localparam int TICKS_OVERSAMPLING = 16;
    localparam int DEFAULT_MAXTAM     = 8;
    localparam int TICK_W             = 5;

endpackage

// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter: start bit, MAXTAM data bits LSB first,
// optional parity bit, SB_TICKS/16 stop bits. Bit timing comes from an
// external 16x oversampling tick (i_bd) shared with the receiver.
//
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even parity, or odd when PARITY_ODD=1). Without it the frame
// goes straight from the last data bit to the stop period.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     asynchronous reset, active low
//   i_bd        one-cycle oversampling tick, 16 per bit period
//   i_tx_start  send request, only looked at while idle
//   i_tx_data   word to send, captured when the request is accepted
//   o_tx        serial line (registered, idles high)
//   o_tx_busy   high while a frame is in flight
//   o_tx_done   one-cycle pulse after the last stop tick
module uart_tx
    import uart_pkg::*;
#(
    parameter int MAXTAM      = DEFAULT_MAXTAM,
    parameter int BIT_COUNTER = 3,
    parameter int SB_TICKS    = 16,
    parameter int PARITY_ODD  = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_bd,
    input  logic              i_tx_start,
    input  logic [MAXTAM-1:0] i_tx_data,
    output logic              o_tx,
    output logic              o_tx_busy,
    output logic              o_tx_done
);

    localparam logic [TICK_W-1:0]      LAST_TICK = TICK_W'(TICKS_OVERSAMPLING - 1);
    localparam logic [TICK_W-1:0]      LAST_STOP = TICK_W'(SB_TICKS - 1);
    localparam logic [BIT_COUNTER-1:0] LAST_BIT  = BIT_COUNTER'(MAXTAM - 1);

    tx_state_t               state, state_n;
    logic [TICK_W-1:0]       tick, tick_n;
    logic [BIT_COUNTER-1:0]  idx, idx_n;
    logic [MAXTAM-1:0]       shift, shift_n;
    logic                    tx_r, tx_n;
    logic                    busy_r, busy_n;
    logic                    done_r, done_n;
`ifdef UART_TX_PARITY_EN
    // Parity is taken from the word at acceptance, since the shift
    // register no longer holds it once the data bits have gone out.
    logic                    par_r, par_n;
`else
    // Parity polarity is meaningless when no parity bit is sent.
    if (PARITY_ODD != 0) begin : g_parity_ignored
    end
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state  <= ST_IDLE;
            tick   <= '0;
            idx    <= '0;
            shift  <= '0;
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_r  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            tick   <= tick_n;
            idx    <= idx_n;
            shift  <= shift_n;
            tx_r   <= tx_n;
            busy_r <= busy_n;
            done_r <= done_n;
`ifdef UART_TX_PARITY_EN
            par_r  <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick;
        idx_n   = idx;
        shift_n = shift;
        done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_r;
`endif

        case (state)
            ST_IDLE: begin
                if (i_tx_start) begin
                    shift_n = i_tx_data;
                    tick_n  = '0;
                    state_n = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_n   = (^i_tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            ST_START: begin
                if (i_bd) begin
                    if (tick == LAST_TICK) begin
                        tick_n  = '0;
                        idx_n   = '0;
                        state_n = ST_DATA;
                    end else begin
                        tick_n = tick + TICK_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_bd) begin
                    if (tick == LAST_TICK) begin
                        tick_n  = '0;
                        shift_n = shift >> 1;
                        if (idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_n = ST_PARITY;
`else
                            state_n = ST_STOP;
`endif
                        end else begin
                            idx_n = idx + BIT_COUNTER'(1);
                        end
                    end else begin
                        tick_n = tick + TICK_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (i_bd) begin
                    if (tick == LAST_TICK) begin
                        tick_n  = '0;
                        state_n = ST_STOP;
                    end else begin
                        tick_n = tick + TICK_W'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (i_bd) begin
                    if (tick == LAST_STOP) begin
                        tick_n  = '0;
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        tick_n = tick + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                tick_n  = '0;
            end
        endcase

        // The pin level is decided from the state being entered so that the
        // registered output changes on the same edge as the state.
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_n = par_n;
`endif
            default:   tx_n = 1'b1;
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    assign o_tx      = tx_r;
    assign o_tx_busy = busy_r;
    assign o_tx_done = done_r;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes one MAXTAM-bit word per request onto a single line in the 8N1-style frame: start bit, data LSB-first, optional parity bit, stop bit(s). It shares the baud-rate generator's 16x oversampling tick (`i_bd`) with the UART receiver. It sits between the host-side interface logic (ALU/command FSM) and the serial TX pin.

## Interface
- `MAXTAM`, 8, data bits per frame (5..8 supported)
- `BIT_COUNTER`, 3, width of data-bit index; must satisfy 2^BIT_COUNTER >= MAXTAM
- `SB_TICKS`, 16, i_bd ticks in stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2); max 32
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity (only meaningful with UART_TX_PARITY_EN)
- `i_clk`  in  1  system clock, all logic on rising edge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_bd`  in  1  one-cycle oversampling tick, 16 per bit period
- `i_tx_start`  in  1  request to send `i_tx_data`; sampled in IDLE only
- `i_tx_data`  in  MAXTAM  word to transmit; captured on accepted request
- `o_tx`  out  1  serial line, idle high
- `o_tx_busy`  out  1  high from acceptance cycle+1 until frame end
- `o_tx_done`  out  1  one-cycle pulse at frame completion

## Operation
- Reset (async assert, i_reset=0): state IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, tick count 0, bit index 0, shift register 0.
- States (one-hot): IDLE, START, DATA, PARITY, STOP.
- IDLE: o_tx=1. If i_tx_start=1: latch i_tx_data into shift register, clear tick count, go START. i_tx_start in any other state is ignored (no queuing).
- START: o_tx=0. On each i_bd: if count==15 -> count=0, bit index=0, go DATA; else count+1.
- DATA: o_tx=shift[0]. On i_bd with count==15: count=0, shift right by 1; if index==MAXTAM-1 go PARITY (macro on) or STOP (macro off), else index+1.
- PARITY: o_tx = XOR of the latched word (even) or its inverse (odd); 16 ticks, then STOP. Parity computed from the word at acceptance, not from the shifted register.
- STOP: o_tx=1. On i_bd with count==SB_TICKS-1: go IDLE, assert o_tx_done for one cycle.
- Tick counter width 5 bits (covers SB_TICKS up to 32); counts wrap only via explicit clear.
- o_tx driven from a register (no combinational glitches on the pin).

## Timing
- Acceptance: i_tx_start=1 in IDLE at edge N -> o_tx=0 and o_tx_busy=1 from edge N+1.
- Each start/data/parity bit lasts exactly 16 i_bd ticks; stop lasts SB_TICKS ticks.
- o_tx_done=1 for exactly the cycle following the final stop tick; o_tx_busy=0 in that same cycle; state is IDLE.
- i_tx_start asserted in the o_tx_done cycle is accepted (back-to-back frames, no extra idle bit).
- i_bd held low: FSM and o_tx frozen indefinitely.
- Reset mid-frame: o_tx returns to 1 immediately (asynchronously), frame aborted, no o_tx_done.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state compiled in; frame = 1 + MAXTAM + 1 + stop.
- Undefined: PARITY state and parity logic absent; DATA goes directly to STOP; PARITY_ODD ignored.

## Structure
- Shared package `uart_pkg`: state encodings (IDLE/START/DATA/PARITY/STOP one-hot), TICKS_OVERSAMPLING=16, default MAXTAM; reused by the receiver.
- No sub-module needed; single FSM plus datapath registers. Baud-rate generator stays external.

## Test plan
- i_bd every cycle, macro off, send 0x55 -> o_tx: 16 cycles 0, then bits 1,0,1,0,1,0,1,0 each 16 cycles, 16 cycles 1; o_tx_done pulse at cycle 161 after acceptance.
- i_bd every 4th cycle, send 0xA3 -> each bit 64 clocks; captured frame decodes to 0xA3; receiver loopback reports o_Rx_Byte=0xA3 with o_Rx_Done.
- Macro on, PARITY_ODD=0, send 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; send 0x00 even -> 0.
- Back-to-back: i_tx_start held high with 0x11 then 0x22 -> second start bit begins the cycle after o_tx_done, no idle gap; i_tx_start pulses mid-frame ignored.
- SB_TICKS=32 -> stop period 32 ticks; o_tx_busy low only after.
- Assert i_reset=0 during DATA bit 3 -> o_tx=1, o_tx_busy=0 same cycle, no o_tx_done; next request transmits cleanly.
